// File: rtl/sap_1_microsequencer.sv
// sap_1_microsequencer
//
// Control sequencer for the SAP-1 family. It sits between the instruction
// register and the control ROM. Every cycle it supplies the control-ROM
// address (upc). It reads back the end-of-instruction and halt flags of the
// current microword. A run-time writable table maps each opcode to the start
// address of its microroutine.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   run          start from IDLE or resume from HALT
//   map_we       mapping-table write strobe
//   map_waddr    opcode entry to write
//   map_wdata    microroutine start address (a write also marks the entry valid)
//   opcode       instruction-register opcode field
//   uinstr_last  current microword ends its instruction
//   uinstr_halt  current microword is HLT
//   upc          registered control-ROM address
//   t_state      cycle index within the current instruction (saturating)
//   fetch        high while fetching
//   halted       high while halted
//   illegal      sticky flag: an unmapped opcode was dispatched
//
// state | meaning
// IDLE  | after reset, upc parked at 0, waiting for run
// FETCH | shared fetch routine, FETCH_LEN cycles, dispatch on the last one
// EXEC  | stepping through the opcode's microroutine
// HALT  | stopped by HLT or an illegal opcode, waiting for run

module sap_1_microsequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int UADDR_WIDTH  = 6,
    parameter int FETCH_BASE   = 0,
    parameter int FETCH_LEN    = 3,
    parameter int T_WIDTH      = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    map_we,
    input  logic [OPCODE_WIDTH-1:0] map_waddr,
    input  logic [UADDR_WIDTH-1:0]  map_wdata,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    uinstr_last,
    input  logic                    uinstr_halt,
    output logic [UADDR_WIDTH-1:0]  upc,
    output logic [T_WIDTH-1:0]      t_state,
    output logic                    fetch,
    output logic                    halted,
    output logic                    illegal
);

    localparam int MAP_DEPTH = 2 ** OPCODE_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [UADDR_WIDTH-1:0] FETCH_FIRST = UADDR_WIDTH'(FETCH_BASE);
    // The fetch routine runs on consecutive addresses, so its final address
    // identifies the dispatch cycle without a separate counter.
    localparam logic [UADDR_WIDTH-1:0] FETCH_FINAL = UADDR_WIDTH'(FETCH_BASE + FETCH_LEN - 1);
    localparam logic [UADDR_WIDTH-1:0] UPC_ONE     = UADDR_WIDTH'(1);
    localparam logic [T_WIDTH-1:0]     T_ONE       = T_WIDTH'(1);
    localparam logic [T_WIDTH-1:0]     T_MAX       = '1;

    logic [1:0]             state_q, state_d;
    logic [UADDR_WIDTH-1:0] upc_q, upc_d;
    logic [T_WIDTH-1:0]     t_q, t_d;
    logic                   illegal_q, illegal_d;

    logic [UADDR_WIDTH-1:0] map_addr_q [MAP_DEPTH];
    logic [UADDR_WIDTH-1:0] map_addr_d [MAP_DEPTH];
    logic [MAP_DEPTH-1:0]   map_vld_q, map_vld_d;

    logic                   entry_vld;
    logic [UADDR_WIDTH-1:0] entry_addr;
    logic [T_WIDTH-1:0]     t_inc;

    // The lookup reads the registered table. A write in the same cycle
    // therefore takes effect only for later dispatches.
    assign entry_vld  = map_vld_q[opcode];
    assign entry_addr = map_addr_q[opcode];

    assign t_inc = (t_q == T_MAX) ? t_q : t_q + T_ONE;

    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        t_d       = t_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_IDLE: begin
                upc_d = '0;
                if (run) begin
                    state_d = ST_FETCH;
                    upc_d   = FETCH_FIRST;
                    t_d     = '0;
                end
            end

            ST_FETCH: begin
                if (upc_q == FETCH_FINAL) begin
                    if (entry_vld) begin
                        state_d = ST_EXEC;
                        upc_d   = entry_addr;
                        t_d     = t_inc;
                    end else begin
                        // upc and t_state freeze on the cycle that failed dispatch.
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                end else begin
                    upc_d = upc_q + UPC_ONE;
                    t_d   = t_inc;
                end
            end

            ST_EXEC: begin
                if (uinstr_halt) begin
                    state_d = ST_HALT;
                end else if (uinstr_last) begin
                    state_d = ST_FETCH;
                    upc_d   = FETCH_FIRST;
                    t_d     = '0;
                end else begin
                    upc_d = upc_q + UPC_ONE;
                    t_d   = t_inc;
                end
            end

            ST_HALT: begin
                if (run) begin
                    state_d   = ST_FETCH;
                    upc_d     = FETCH_FIRST;
                    t_d       = '0;
                    illegal_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                upc_d   = '0;
                t_d     = '0;
            end
        endcase
    end

    always_comb begin
        map_addr_d = map_addr_q;
        map_vld_d  = map_vld_q;
        if (map_we) begin
            map_addr_d[map_waddr] = map_wdata;
            map_vld_d[map_waddr]  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            upc_q      <= '0;
            t_q        <= '0;
            illegal_q  <= 1'b0;
            map_addr_q <= '{default: '0};
            map_vld_q  <= '0;
        end else begin
            state_q    <= state_d;
            upc_q      <= upc_d;
            t_q        <= t_d;
            illegal_q  <= illegal_d;
            map_addr_q <= map_addr_d;
            map_vld_q  <= map_vld_d;
        end
    end

    assign upc     = upc_q;
    assign t_state = t_q;
    assign fetch   = (state_q == ST_FETCH);
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_sap_1_microsequencer.sv
module tb_sap_1_microsequencer;

    localparam int OW    = 4;
    localparam int UW    = 6;
    localparam int FB    = 0;
    localparam int FL    = 3;
    localparam int TW    = 3;
    localparam int UDEP  = 64;
    localparam int TMAX  = 7;

    logic          clock = 1'b0;
    logic          reset;
    logic          run;
    logic          map_we;
    logic [OW-1:0] map_waddr;
    logic [UW-1:0] map_wdata;
    logic [OW-1:0] opcode;
    logic          uinstr_last;
    logic          uinstr_halt;
    logic [UW-1:0] upc;
    logic [TW-1:0] t_state;
    logic          fetch;
    logic          halted;
    logic          illegal;

    // Control ROM flags, looked up combinationally at the DUT's address.
    bit rom_last [UDEP];
    bit rom_halt [UDEP];

    assign uinstr_last = rom_last[upc];
    assign uinstr_halt = rom_halt[upc];

    sap_1_microsequencer #(
        .OPCODE_WIDTH (OW),
        .UADDR_WIDTH  (UW),
        .FETCH_BASE   (FB),
        .FETCH_LEN    (FL),
        .T_WIDTH      (TW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .map_we      (map_we),
        .map_waddr   (map_waddr),
        .map_wdata   (map_wdata),
        .opcode      (opcode),
        .uinstr_last (uinstr_last),
        .uinstr_halt (uinstr_halt),
        .upc         (upc),
        .t_state     (t_state),
        .fetch       (fetch),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the expected outputs, the fetch cycle index and
    // whether an instruction body is running.
    int m_upc, m_t, m_fcnt;
    bit m_fetch, m_exec, m_halted, m_illegal;
    int map_val [16];
    bit map_ok  [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_upc = 0; m_t = 0; m_fcnt = 0;
        m_fetch = 0; m_exec = 0; m_halted = 0; m_illegal = 0;
        for (int i = 0; i < 16; i++) begin
            map_val[i] = 0;
            map_ok[i]  = 0;
        end
    endtask

    task automatic enter_fetch();
        m_fetch = 1; m_exec = 0; m_halted = 0;
        m_upc = FB; m_t = 0; m_fcnt = 0;
    endtask

    task automatic model_step();
        int t_sat;
        t_sat = (m_t == TMAX) ? m_t : m_t + 1;
        if (m_exec) begin
            if (rom_halt[m_upc]) begin
                m_exec = 0; m_halted = 1;
            end else if (rom_last[m_upc]) begin
                enter_fetch();
            end else begin
                m_upc = (m_upc + 1) % UDEP;
                m_t   = t_sat;
            end
        end else if (m_fetch) begin
            if (m_fcnt == FL - 1) begin
                m_fetch = 0;
                if (map_ok[opcode]) begin
                    m_exec = 1;
                    m_upc  = map_val[opcode];
                    m_t    = t_sat;
                end else begin
                    m_halted  = 1;
                    m_illegal = 1;
                end
            end else begin
                m_fcnt++;
                m_upc = (m_upc + 1) % UDEP;
                m_t   = t_sat;
            end
        end else if (m_halted) begin
            if (run) begin
                m_illegal = 0;
                enter_fetch();
            end
        end else if (run) begin
            enter_fetch();
        end
        if (map_we) begin
            map_val[map_waddr] = int'(map_wdata);
            map_ok[map_waddr]  = 1;
        end
    endtask

    task automatic check_outputs();
        chk("upc", 32'(upc), m_upc);
        chk("t_state", 32'(t_state), m_t);
        chk("fetch", 32'(fetch), 32'(m_fetch));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("illegal", 32'(illegal), 32'(m_illegal));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic write_map(input int a, input int d);
        map_we    = 1'b1;
        map_waddr = OW'(a);
        map_wdata = UW'(d);
        cycle();
        map_we    = 1'b0;
    endtask

    // Called just after a rising edge; reset acts before the next edge.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        chk("rst_upc", 32'(upc), 0);
        chk("rst_t", 32'(t_state), 0);
        chk("rst_fetch", 32'(fetch), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        model_reset();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; map_we = 1'b0;
        map_waddr = '0; map_wdata = '0; opcode = '0;
        for (int i = 0; i < UDEP; i++) begin
            rom_last[i] = 0;
            rom_halt[i] = 0;
        end
        #2;
        chk("por_upc", 32'(upc), 0);
        chk("por_t", 32'(t_state), 0);
        chk("por_fetch", 32'(fetch), 0);
        chk("por_halted", 32'(halted), 0);
        chk("por_illegal", 32'(illegal), 0);
        model_reset();
        reset = 1'b0;

        // Basic fetch/execute of opcode 0 -> 3, ending at 5.
        write_map(0, 3); write_map(1, 6); write_map(2, 9);
        write_map(14, 12); write_map(15, 13);
        rom_last[5]  = 1;
        rom_halt[13] = 1;
        rom_last[13] = 1;
        opcode = 4'd0; run = 1'b1;
        cycle();
        chk("s1_fetch_entry", 32'(fetch), 1);
        chk("s1_upc_entry", 32'(upc), 0);
        run = 1'b0;
        repeat (6) cycle();
        chk("s1_back_upc", 32'(upc), 0);
        chk("s1_back_fetch", 32'(fetch), 1);

        // HLT with last also set: halt wins.
        opcode = 4'd15;
        repeat (4) cycle();
        chk("s2_halt_upc", 32'(upc), 13);
        chk("s2_halted", 32'(halted), 1);
        run = 1'b1; cycle(); run = 1'b0;
        chk("s2_resume_upc", 32'(upc), 0);
        chk("s2_resume_halted", 32'(halted), 0);

        // Unmapped opcode.
        opcode = 4'd7;
        repeat (3) cycle();
        chk("s3_illegal", 32'(illegal), 1);
        chk("s3_upc_hold", 32'(upc), 2);
        run = 1'b1; cycle(); run = 1'b0;
        chk("s3_illegal_clr", 32'(illegal), 0);
        chk("s3_upc", 32'(upc), 0);

        // Wrap 3F -> 00 and t_state saturation over 8 EXEC cycles.
        rom_last[5] = 0;
        rom_last[6] = 1;
        opcode = 4'd3;
        map_we = 1'b1; map_waddr = 4'd3; map_wdata = 6'h3F;
        cycle();
        map_we = 1'b0;
        repeat (2) cycle();
        chk("s4_upc_3f", 32'(upc), 32'h3F);
        cycle();
        chk("s4_wrap", 32'(upc), 0);
        repeat (6) cycle();
        chk("s4_upc6", 32'(upc), 6);
        chk("s4_t_sat", 32'(t_state), 7);
        cycle();
        chk("s4_refetch", 32'(upc), 0);

        // Write to the entry being looked up: old value used first.
        rom_last[32] = 1;
        opcode = 4'd1;
        repeat (2) cycle();
        map_we = 1'b1; map_waddr = 4'd1; map_wdata = 6'h20;
        cycle();
        map_we = 1'b0;
        chk("s5_old_map", 32'(upc), 6);
        repeat (4) cycle();
        chk("s5_new_map", 32'(upc), 32'h20);
        cycle();

        // Async reset in EXEC at upc 7, then the table is gone.
        rom_last[6] = 0;
        opcode = 4'd0;
        repeat (7) cycle();
        chk("s6_pre_upc", 32'(upc), 7);
        async_reset();
        run = 1'b1; cycle(); run = 1'b0;
        repeat (3) cycle();
        chk("s6_illegal", 32'(illegal), 1);
        chk("s6_halted", 32'(halted), 1);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 10; seg++) begin
            for (int i = 0; i < UDEP; i++) begin
                rom_last[i] = ($urandom_range(0, 3) == 0);
                rom_halt[i] = ($urandom_range(0, 15) == 0);
            end
            for (int c = 0; c < 200; c++) begin
                run       = ($urandom_range(0, 3) == 0);
                opcode    = OW'($urandom);
                map_we    = ($urandom_range(0, 5) == 0);
                map_waddr = OW'($urandom);
                map_wdata = UW'($urandom);
                if ($urandom_range(0, 299) == 0) async_reset();
                else cycle();
            end
        end
        map_we = 1'b0;
        run    = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sap_1_microsequencer.md
# sap_1_microsequencer

Parametrised control sequencer for the SAP-1 family. It replaces the fixed opcode-to-address decode with a run-time writable mapping table, and adds a microprogram counter, fetch/execute state machine, halt and illegal-opcode handling. It sits between the instruction register and the control ROM: it sources the control-ROM address every cycle and takes the end-of-instruction and halt flags back from the microword.

## Interface
- OPCODE_WIDTH, 4, opcode width; mapping table holds 2**OPCODE_WIDTH entries
- UADDR_WIDTH, 6, control-ROM address width
- FETCH_BASE, 0, first microaddress of the shared fetch routine
- FETCH_LEN, 3, fetch routine length in cycles (>=1)
- T_WIDTH, 3, width of the T-state counter

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  start from IDLE or resume from HALT; ignored in FETCH/EXEC
- map_we  in  1  mapping-table write enable
- map_waddr  in  OPCODE_WIDTH  entry to write
- map_wdata  in  UADDR_WIDTH  start microaddress; a write also sets the entry valid
- opcode  in  OPCODE_WIDTH  instruction-register opcode field
- uinstr_last  in  1  current microword is the last of its instruction (combinational from ROM at upc)
- uinstr_halt  in  1  current microword is HLT
- upc  out  UADDR_WIDTH  registered control-ROM address
- t_state  out  T_WIDTH  cycle index within current instruction
- fetch  out  1  high while in FETCH
- halted  out  1  high while in HALT
- illegal  out  1  sticky: an unmapped opcode was dispatched

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset forces IDLE, clears all table valid bits and entries to 0. Outputs after reset: upc=0, t_state=0, fetch=0, halted=0, illegal=0.
- IDLE: upc=0. run=1 -> FETCH with upc=FETCH_BASE, t_state=0.
- FETCH: upc increments each cycle from FETCH_BASE through FETCH_BASE+FETCH_LEN-1. On the last fetch cycle, opcode is sampled and its entry looked up:
  - valid -> EXEC, upc=entry
  - invalid -> HALT, illegal=1, upc holds
- EXEC: upc increments each cycle, modulo 2**UADDR_WIDTH (wraps, no flag).
  - uinstr_halt=1 -> HALT, upc holds. Halt has priority over uinstr_last.
  - uinstr_last=1 (no halt) -> FETCH, upc=FETCH_BASE, t_state=0.
- HALT: upc and t_state hold, halted=1. run=1 -> FETCH with upc=FETCH_BASE, t_state=0; illegal clears on that transition.
- t_state: 0 on FETCH entry, +1 per cycle through FETCH and EXEC, saturates at 2**T_WIDTH-1.
- Mapping writes are accepted in any state. A lookup in the same cycle as a write to the same entry uses the old contents; the new value is visible the next cycle.
- uinstr_last and uinstr_halt are ignored outside EXEC.

## Timing
- upc, t_state, fetch and halted are registered; the state is visible on outputs in the cycle after the deciding edge.
- run high in IDLE at edge n -> upc=FETCH_BASE, fetch=1 after edge n.
- Fetch-to-execute latency is FETCH_LEN cycles: the first EXEC upc follows edge FETCH_LEN after FETCH entry.
- uinstr_last or uinstr_halt sampled at edge k (with upc=a) -> upc=FETCH_BASE or hold a, respectively, after edge k.
- A single-microword instruction (uinstr_last=1 at its entry address) costs FETCH_LEN+1 cycles.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. Table contents are lost; the first run after deassertion starts a fresh fetch.

## Test plan
- Reset, then write map 0->3, 1->6, 2->9, E->C. Pulse run, opcode=0, uinstr_last at upc=5 -> upc sequence 0,1,2,3,4,5,0; t_state 0..5; fetch high for 3 cycles.
- Opcode F mapped to D, with uinstr_halt at upc=D and uinstr_last also high -> HALT with upc held at D, halted=1. Then run=1 -> upc=0, halted=0.
- Opcode 7 never written -> after the third fetch cycle: illegal=1, halted=1, upc held at 2. Then run -> illegal=0, upc=0.
- Map 3->3F, uinstr_last low at 3F -> upc wraps 3F->00 in EXEC. Hold for 8 EXEC cycles -> t_state saturates at 7.
- In the last fetch cycle with opcode=1, write map 1->20 -> dispatch to 6 (old value); the next opcode=1 dispatch goes to 20.
- Assert reset while in EXEC at upc=7 -> all outputs 0 with no clock edge, state IDLE. The previously mapped opcode 0 then dispatches as illegal.
